mem_store_sequencer: RTL and testbench

Write-side companion to the memory register banks. It accepts byte, halfword and word store requests over a valid/ready handshake and queues them in a small FIFO. It then drives them into the word-wide memory write port as one or two byte-enabled word writes, splitting any store that crosses a word boundary. It sits between the CPU store stage and the memory array whose register cells are read back by the load path.

---
 rtl/mem_store_pkg.sv | 66 ++++++
 rtl/mem_store_fifo.sv | 84 ++++++++
 rtl/mem_store_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_store_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_pkg
// Description : Shared encodings for the store sequencer. Covers the store
//               size codes, the FSM states, the per-size base byte masks, and
//               the little-endian lane placement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_store_pkg;

  // Store size encodings (req_size)
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  // Byte-enable patterns before shifting by the address offset
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Lane placement of one store across the first and (optional) second word
  typedef struct packed {
    logic [3:0]  be_lo;
    logic [3:0]  be_hi;
    logic [31:0] wd_lo;
    logic [31:0] wd_hi;
  } lanes_t;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = MASK_B;
      SZ_H:    m = MASK_H;
      SZ_W:    m = MASK_W;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Shift the mask and data into an 8-lane window; the upper four lanes
  // belong to the following word and are non-zero only for split stores.
  function automatic lanes_t lane_calc(input logic [1:0]  size,
                                       input logic [1:0]  off,
                                       input logic [31:0] data);
    lanes_t     l;
    logic [7:0] m;
    logic [63:0] w;
    m       = {4'b0000, base_mask(size)} << off;
    w       = {32'h0000_0000, data} << {off, 3'b000};
    l.be_lo = m[3:0];
    l.be_hi = m[7:4];
    l.wd_lo = w[31:0];
    l.wd_hi = w[63:32];
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_store_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_fifo
// Description : Small store-request FIFO. Push and pop are qualified by the
//               clock enable. A full FIFO refuses a push even when a pop
//               happens on the same edge. Exposes both the head entry and the
//               entry behind it, so the sequencer can chain entries without
//               a bubble.
// Ports       : i_clk, i_rst_n (async, active-low), i_tick (clock enable)
//               i_push/i_wdata  - write request and entry
//               i_pop           - remove head entry
//               o_head/o_next   - entry at read pointer and the one after it
//               o_count/o_full/o_empty - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module mem_store_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 66,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [WIDTH-1:0] o_next,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_rd_next;

  assign o_full    = (r_count == C_DEPTH);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_tick & i_push & ~o_full;
  assign w_pop_ok  = i_tick & i_pop & ~o_empty;
  // DEPTH is a power of two, so pointer arithmetic wraps naturally
  assign w_rd_next = r_rd_ptr + PTR_W'(1);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_next    = r_mem[w_rd_next];

  // Storage carries no reset; occupancy alone decides validity
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_store_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_sequencer
// Description : Accepts byte/half/word stores over valid/ready and queues
//               them. It then issues each store to a word-wide memory write
//               port as one or two byte-enabled word writes. A second write
//               is issued when the store crosses a word boundary.
// Ports       : i_clk, i_rst_n (async, active-low), i_tick (clock enable)
//               i_req_valid/o_req_ready, i_req_addr, i_req_size, i_req_data
//               o_mem_req/i_mem_ack, o_mem_addr (word), o_mem_wdata, o_mem_be
//               o_busy     - queued entries or access in flight
//               o_size_err - one-cycle pulse after a reserved-size accept
// Revision    : 1.0 - initial release
// ============================================================================
module mem_store_sequencer
  import mem_store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic [31:0]       i_req_data,
  output logic              o_mem_req,
  input  logic              i_mem_ack,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  output logic              o_busy,
  output logic              o_size_err
);

  localparam int               ENTRY_W = ADDR_W + 2 + 32;
  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam int               WADDR_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);

  // Entry layout: {addr, size, data}
  logic [ENTRY_W-1:0] w_req_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_next;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_queue;
  logic               w_push;
  logic               w_pop;
  logic               w_ack;

  logic [ENTRY_W-1:0] w_load_entry;
  logic [ADDR_W-1:0]  w_load_addr;
  logic [WADDR_W-1:0] w_load_word;
  lanes_t             w_lanes;
  logic               w_next_avail;
  logic               w_load;
  logic               w_finish;

  state_e             r_state;
  logic               r_mem_req;
  logic [WADDR_W-1:0] r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [3:0]         r_mem_be;
  logic [WADDR_W-1:0] r_hi_addr;
  logic [31:0]        r_hi_wdata;
  logic [3:0]         r_hi_be;
  logic               r_split;
  logic               r_size_err;

  state_e             w_state_nxt;
  logic               w_mem_req_nxt;
  logic [WADDR_W-1:0] w_mem_addr_nxt;
  logic [31:0]        w_mem_wdata_nxt;
  logic [3:0]         w_mem_be_nxt;
  logic [WADDR_W-1:0] w_hi_addr_nxt;
  logic [31:0]        w_hi_wdata_nxt;
  logic [3:0]         w_hi_be_nxt;
  logic               w_split_nxt;
  logic               w_size_err_nxt;

  // Ready is held low while reset is asserted, independent of occupancy
  assign o_req_ready = i_rst_n & ~w_full;
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_queue     = w_accept & (i_req_size != SZ_RSV);
  assign w_push      = w_queue & i_tick;
  assign w_ack       = i_tick & r_mem_req & i_mem_ack;
  assign w_req_entry = {i_req_addr, i_req_size, i_req_data};

  mem_store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_tick),
    .i_push  (w_queue),
    .i_wdata (w_req_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // When finishing an entry, the successor is either already queued behind
  // the head, or (head being the only entry) the request being pushed now.
  assign w_next_avail = (w_count >= C_TWO) | w_push;
  assign w_load_entry = (r_state == ST_IDLE) ? w_head :
                        ((w_count >= C_TWO) ? w_next : w_req_entry);
  assign w_load_addr  = w_load_entry[ENTRY_W-1 -: ADDR_W];
  assign w_load_word  = w_load_addr[ADDR_W-1:2];
  assign w_lanes      = lane_calc(w_load_entry[33:32], w_load_addr[1:0],
                                  w_load_entry[31:0]);

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_hi_addr_nxt   = r_hi_addr;
    w_hi_wdata_nxt  = r_hi_wdata;
    w_hi_be_nxt     = r_hi_be;
    w_split_nxt     = r_split;
    w_size_err_nxt  = r_size_err;
    w_pop           = 1'b0;
    w_load          = 1'b0;
    w_finish        = 1'b0;

    if (i_tick) begin
      w_size_err_nxt = w_accept & (i_req_size == SZ_RSV);
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_load = 1'b1;
          end
        end
        ST_LO: begin
          if (w_ack) begin
            if (r_split) begin
              w_state_nxt     = ST_HI;
              w_mem_addr_nxt  = r_hi_addr;
              w_mem_wdata_nxt = r_hi_wdata;
              w_mem_be_nxt    = r_hi_be;
            end else begin
              w_finish = 1'b1;
            end
          end
        end
        ST_HI: begin
          if (w_ack) begin
            w_finish = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
        end
      endcase

      if (w_finish) begin
        w_pop = 1'b1;
        if (w_next_avail) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
        end
      end

      if (w_load) begin
        w_state_nxt     = ST_LO;
        w_mem_req_nxt   = 1'b1;
        w_mem_addr_nxt  = w_load_word;
        w_mem_wdata_nxt = w_lanes.wd_lo;
        w_mem_be_nxt    = w_lanes.be_lo;
        w_hi_addr_nxt   = w_load_word + WADDR_W'(1);
        w_hi_wdata_nxt  = w_lanes.wd_hi;
        w_hi_be_nxt     = w_lanes.be_hi;
        w_split_nxt     = |w_lanes.be_hi;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_hi_addr   <= '0;
      r_hi_wdata  <= '0;
      r_hi_be     <= '0;
      r_split     <= 1'b0;
      r_size_err  <= 1'b0;
    end else begin
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_hi_addr   <= w_hi_addr_nxt;
      r_hi_wdata  <= w_hi_wdata_nxt;
      r_hi_be     <= w_hi_be_nxt;
      r_split     <= w_split_nxt;
      r_size_err  <= w_size_err_nxt;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_size_err  = r_size_err;
  assign o_busy      = (r_state != ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_store_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_store_sequencer
// Description : Directed self-checking bench for mem_store_sequencer. Expected
//               memory accesses come from a byte-walk model and are queued
//               when a store is handshaken. They are compared as the DUT's
//               accesses are acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_store_sequencer;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        tick      = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr  = '0;
  logic [1:0]  req_size  = '0;
  logic [31:0] req_data  = '0;
  logic        mem_req;
  logic        mem_ack   = 1'b0;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        size_err;

  mem_store_sequencer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tick      (tick),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_size  (req_size),
    .i_req_data  (req_data),
    .o_mem_req   (mem_req),
    .i_mem_ack   (mem_ack),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_be    (mem_be),
    .o_busy      (busy),
    .o_size_err  (size_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Walk the stored bytes one at a time; bytes landing in the next word go
  // to the second access, whose word address wraps with 30-bit arithmetic.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] d);
    acc_t        lo;
    acc_t        hi;
    logic [31:0] ba;
    int          nb;
    lo      = '0;
    hi      = '0;
    lo.addr = a[31:2];
    hi.addr = a[31:2] + 30'd1;
    nb      = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    for (int j = 0; j < nb; j++) begin
      ba = a + 32'(j);
      if (ba[31:2] == lo.addr) begin
        lo.be[ba[1:0]]           = 1'b1;
        lo.wdata[8*ba[1:0] +: 8] = d[8*j +: 8];
      end else begin
        hi.be[ba[1:0]]           = 1'b1;
        hi.wdata[8*ba[1:0] +: 8] = d[8*j +: 8];
      end
    end
    exp_q.push_back(lo);
    if (hi.be != 4'b0000) exp_q.push_back(hi);
  endfunction

  // Accesses accepted at the coming edge are sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && tick && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL unexpected_access: observed addr 0x%0h be 0x%0h, required no access",
               mem_addr, mem_be);
      end else begin
        mon_e = exp_q.pop_front();
        check("acc_addr",  64'(mem_addr),  64'(mon_e.addr));
        check("acc_be",    64'(mem_be),    64'(mon_e.be));
        check("acc_wdata", 64'(mem_wdata), 64'(mon_e.wdata));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Handshake one request; returns #1 after the accepting edge
  task automatic push(input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] d);
    int k;
    k         = 0;
    req_addr  = a;
    req_size  = sz;
    req_data  = d;
    req_valid = 1'b1;
    while (!(req_ready && tick) && k < 40) begin
      cyc(1);
      k++;
    end
    check("push_ready_within_bound", 64'(k < 40), 64'd1);
    if (k < 40) begin
      if (sz != 2'b11) model(a, sz, d);
      cyc(1);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 60) begin
      cyc(1);
      k++;
    end
    check(tag, 64'(busy), 64'd0);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_be",    64'(mem_be),    64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_size_err",  64'(size_err),  64'd0);
    cyc(2);
    rst_n = 1'b1;
    tick  = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    cyc(1);

    // ---------------- aligned word, ack tied high ----------------
    mem_ack = 1'b1;
    push(32'h0000_0100, 2'b10, 32'hDEAD_BEEF);
    check("sw_busy_after_push",   64'(busy),    64'd1);
    check("sw_no_req_yet",        64'(mem_req), 64'd0);
    cyc(1);
    check("sw_req_k1",            64'(mem_req),  64'd1);
    check("sw_addr",              64'(mem_addr), 64'h40);
    check("sw_be",                64'(mem_be),   64'hF);
    cyc(1);
    check("sw_done_k2_req",       64'(mem_req), 64'd0);
    check("sw_done_k2_busy",      64'(busy),    64'd0);

    // ---------------- split halfword ----------------
    push(32'h0000_0203, 2'b01, 32'h0000_ABCD);
    cyc(1);
    check("sh_lo_be", 64'(mem_be),    64'h8);
    check("sh_lo_wd", 64'(mem_wdata), 64'hCD00_0000);
    cyc(1);
    check("sh_hi_addr", 64'(mem_addr), 64'h81);
    check("sh_hi_be",   64'(mem_be),   64'h1);
    cyc(1);
    check("sh_done_k3_req", 64'(mem_req), 64'd0);
    wait_idle("sh_idle");

    // ---------------- byte, then wrapping split ----------------
    push(32'h0000_0002, 2'b00, 32'h0000_0077);
    push(32'hFFFF_FFFF, 2'b01, 32'h0000_1234);
    wait_idle("wrap_idle");

    // ---------------- stall with full FIFO ----------------
    mem_ack = 1'b0;
    push(32'h0000_0400, 2'b10, 32'h1111_1111);
    push(32'h0000_0404, 2'b10, 32'h2222_2222);
    req_addr  = 32'h0000_0408;
    req_size  = 2'b10;
    req_data  = 32'h3333_3333;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("stall_ready_low", 64'(req_ready), 64'd0);
      check("stall_req",       64'(mem_req),   64'd1);
      check("stall_addr",      64'(mem_addr),  64'h100);
      check("stall_wdata",     64'(mem_wdata), 64'h1111_1111);
    end
    mem_ack = 1'b1;
    push(32'h0000_0408, 2'b10, 32'h3333_3333);
    wait_idle("stall_idle");

    // ---------------- reserved size and Tick hold ----------------
    push(32'h0000_0010, 2'b11, 32'h0000_00AA);
    check("rsv_size_err", 64'(size_err), 64'd1);
    check("rsv_no_req",   64'(mem_req),  64'd0);
    check("rsv_not_busy", 64'(busy),     64'd0);
    tick = 1'b0;
    cyc(3);
    check("rsv_err_held_tick0", 64'(size_err), 64'd1);
    tick = 1'b1;
    cyc(1);
    check("rsv_err_cleared", 64'(size_err), 64'd0);

    push(32'h0000_0500, 2'b10, 32'h5555_5555);
    cyc(1);
    tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("tick0_req_held",  64'(mem_req),  64'd1);
      check("tick0_addr_held", 64'(mem_addr), 64'h140);
    end
    tick = 1'b1;
    wait_idle("tick_idle");

    // ---------------- reset during second access ----------------
    mem_ack = 1'b0;
    push(32'h0000_0203, 2'b01, 32'h0000_ABCD);
    cyc(1);
    mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    check("hi_before_reset_req", 64'(mem_req), 64'd1);
    check("hi_before_reset_be",  64'(mem_be),  64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req",   64'(mem_req),   64'd0);
    check("async_rst_busy",  64'(busy),      64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
    #1;
    check("rerelease_ready", 64'(req_ready), 64'd1);
    mem_ack = 1'b1;
    cyc(5);
    check("no_stale_req",  64'(mem_req), 64'd0);
    check("no_stale_busy", 64'(busy),    64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
